// File: rtl/axi_burst_mem_pkg.sv
// axi_burst_mem_pkg: FSM state types, LFSR taps and address-to-word mapping for axi_burst_mem_responder.
package axi_burst_mem_pkg;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [31:0] word_index(input logic [63:0] addr, input int unsigned lsb, input int unsigned depth);
    return 32'((addr >> lsb) & 64'(depth - 1));
  endfunction
endpackage

// File: rtl/axi_burst_mem_array.sv
// axi_burst_mem_array: word array with byte-strobed synchronous write and registered read (old data on same-word collision).
module axi_burst_mem_array
  import axi_burst_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic              re,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_W/8; b++)
      if (we && wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
    if (rst) rdata_q <= '0;
    else if (re) rdata_q <= mem[ridx];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/axi_burst_mem_responder.sv
// axi_burst_mem_responder: AXI INCR-burst subordinate memory with independent read/write FSMs.
// Define AXI_SLV_BACKPRESSURE_EN to throttle wready/rvalid from a 16-bit LFSR.
module axi_burst_mem_responder
  import axi_burst_mem_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int MEM_DEPTH_WORDS    = 4096,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            proto_err
);
  localparam int LSB   = $clog2(C_M_AXI_DATA_WIDTH/8);
  localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);
  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d, r_idx_q, r_idx_d, mem_ridx;
  logic [7:0] w_cnt_q, w_cnt_d, w_len_q, w_len_d, r_cnt_q, r_cnt_d, r_len_q, r_len_d;
  logic proto_err_q, proto_err_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic w_gate, r_gate, mem_we, mem_re, w_cnt_last;
`ifdef AXI_SLV_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  always_ff @(posedge clk) lfsr_q <= rst ? LFSR_SEED : lfsr_d;
  assign w_gate = lfsr_q[0];
  assign r_gate = ~lfsr_q[1];
`else
  assign w_gate = 1'b1;
  assign r_gate = 1'b1;
`endif
  assign w_cnt_last = w_cnt_q == w_len_q;
  always_comb begin
    w_state_d     = w_state_q;
    w_idx_d       = w_idx_q;
    w_cnt_d       = w_cnt_q;
    w_len_d       = w_len_q;
    proto_err_d   = proto_err_q;
    mem_we        = 1'b0;
    s_axi_awready = w_state_q == W_IDLE;
    s_axi_wready  = (w_state_q == W_DATA) && w_gate;
    s_axi_bvalid  = w_state_q == W_RESP;
    case (w_state_q)
      W_IDLE: if (s_axi_awvalid) begin
        w_idx_d   = IDX_W'(word_index(64'(s_axi_awaddr), LSB, MEM_DEPTH_WORDS));
        w_cnt_d   = 8'd0;
        w_len_d   = s_axi_awlen;
        w_state_d = W_DATA;
      end
      W_DATA: if (s_axi_wvalid && s_axi_wready) begin
        mem_we  = !rst;
        w_idx_d = w_idx_q + IDX_W'(1);
        w_cnt_d = w_cnt_q + 8'd1;
        // A length mismatch still ends the burst on this beat.
        if (s_axi_wlast || w_cnt_last) w_state_d = W_RESP;
        if (s_axi_wlast != w_cnt_last) proto_err_d = 1'b1;
      end
      W_RESP: if (s_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end
  always_comb begin
    r_state_d     = r_state_q;
    r_idx_d       = r_idx_q;
    r_cnt_d       = r_cnt_q;
    r_len_d       = r_len_q;
    rvalid_d      = rvalid_q;
    rlast_d       = rlast_q;
    mem_re        = 1'b0;
    mem_ridx      = r_idx_q + IDX_W'(1);
    s_axi_arready = r_state_q == R_IDLE;
    case (r_state_q)
      R_IDLE: if (s_axi_arvalid) begin
        mem_re    = 1'b1;
        mem_ridx  = IDX_W'(word_index(64'(s_axi_araddr), LSB, MEM_DEPTH_WORDS));
        r_idx_d   = mem_ridx;
        r_cnt_d   = 8'd0;
        r_len_d   = s_axi_arlen;
        r_state_d = R_DATA;
        rvalid_d  = r_gate;
        rlast_d   = s_axi_arlen == 8'd0;
      end
      R_DATA: if (!rvalid_q) rvalid_d = r_gate;
      else if (s_axi_rready) begin
        if (rlast_q) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
        end else begin
          // Prefetch the next word on the handshake edge for back-to-back beats.
          mem_re   = 1'b1;
          r_idx_d  = mem_ridx;
          r_cnt_d  = r_cnt_q + 8'd1;
          rlast_d  = (r_cnt_q + 8'd1) == r_len_q;
          rvalid_d = r_gate;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      w_idx_q     <= '0;
      w_cnt_q     <= '0;
      w_len_q     <= '0;
      r_idx_q     <= '0;
      r_cnt_q     <= '0;
      r_len_q     <= '0;
      proto_err_q <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      w_idx_q     <= w_idx_d;
      w_cnt_q     <= w_cnt_d;
      w_len_q     <= w_len_d;
      r_idx_q     <= r_idx_d;
      r_cnt_q     <= r_cnt_d;
      r_len_q     <= r_len_d;
      proto_err_q <= proto_err_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
    end
  end
  axi_burst_mem_array #(
    .DATA_W(C_M_AXI_DATA_WIDTH),
    .DEPTH (MEM_DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .widx (w_idx_q),
    .wdata(s_axi_wdata),
    .wstrb(s_axi_wstrb),
    .re   (mem_re),
    .ridx (mem_ridx),
    .rdata(s_axi_rdata)
  );
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rlast  = rlast_q;
  assign proto_err    = proto_err_q;
endmodule

// File: doc/axi_burst_mem_responder.md
Name: axi_burst_mem_responder

Overview:
- Synthesizable AXI-full subordinate memory that answers the vector core's AXI master port (AW/W/B write path, AR/R read path, INCR bursts only).
- Used as the memory end of the vector-core bench and as on-chip scratch memory in standalone builds.
- Read and write channels run as independent FSMs sharing one byte-strobed memory array.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, byte address width.
- C_M_AXI_DATA_WIDTH, 32, data bus width; power of 2, at least 32.
- MEM_DEPTH_WORDS, 4096, memory depth in data words; power of 2.
- LFSR_SEED, 16'hACE1, seed for the optional backpressure LFSR.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axi_awvalid in 1 / s_axi_awready out 1 / s_axi_awaddr in ADDR_W / s_axi_awlen in 8  write address channel
- s_axi_wvalid in 1 / s_axi_wready out 1 / s_axi_wdata in DATA_W / s_axi_wstrb in DATA_W/8 / s_axi_wlast in 1  write data channel
- s_axi_bvalid out 1 / s_axi_bready in 1  write response channel
- s_axi_arvalid in 1 / s_axi_arready out 1 / s_axi_araddr in ADDR_W / s_axi_arlen in 8  read address channel
- s_axi_rvalid out 1 / s_axi_rready in 1 / s_axi_rdata out DATA_W / s_axi_rlast out 1  read data channel
- proto_err  out  1  sticky WLAST/AWLEN mismatch flag

Behaviour:
- Reset (rst=1 on a clk edge):
  - Both FSMs go to idle.
  - awready=1, arready=1; wready, bvalid, rvalid, rlast, proto_err = 0; rdata = 0.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the burst with no response.
- Address mapping:
  - word index = (addr >> log2(DATA_W/8)) mod MEM_DEPTH_WORDS; low address bits are ignored.
  - Burst length = len+1 beats; index increments by 1 per beat and wraps at MEM_DEPTH_WORDS.
- Write FSM, states W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On awvalid&awready, latch the index, clear the beat count and go to W_DATA. wready rises the next cycle.
  - W_DATA: wready=1. Each wvalid&wready writes every byte lane with wstrb set, then index++ and count++.
  - Leaving W_DATA: go to W_RESP on a beat where wlast=1 or count==awlen.
  - If wlast and (count==awlen) disagree, set proto_err; the burst still terminates at that beat.
  - W_RESP: bvalid=1 the cycle after the last beat and holds until bready. The cycle after bvalid&bready: W_IDLE, awready=1.
- Read FSM, states R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On arvalid&arready, rdata is registered from mem[index]. Next cycle: R_DATA, rvalid=1, rlast=(arlen==0).
  - R_DATA: rvalid, rdata and rlast stay stable until rready.
  - On rvalid&rready with no rlast: count++ and rdata is loaded from mem[index+1] in the same edge, giving a back-to-back beat each cycle.
  - rlast=1 exactly when count==arlen.
  - After the rlast handshake: R_IDLE, arready=1 the next cycle.
- Simultaneous events:
  - Read and write channels run concurrently.
  - Same-cycle write and read-load of the same word: the read returns the old data; the write lands.
  - A write to a word already loaded into rdata is not reflected until that word is reloaded.
- Handshake rules:
  - Inputs are sampled only on the handshake cycle.
  - Once asserted, valid outputs never drop before their handshake.

Optional Feature:
- Macro: AXI_SLV_BACKPRESSURE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with LFSR_SEED, steps every cycle.
  - In W_DATA, wready = lfsr[0].
  - In R_DATA, a new beat's rvalid assertion is delayed while lfsr[1]=1; once rvalid is high it stays high until the handshake.
- Undefined: no LFSR; wready and rvalid follow the fixed timing above.

Decomposition:
- Package axi_burst_mem_pkg:
  - w_state_t {W_IDLE, W_DATA, W_RESP} and r_state_t {R_IDLE, R_DATA}.
  - LFSR tap constant.
  - Function word_index(addr).
- Sub-module axi_burst_mem_array: MEM_DEPTH_WORDS x DATA_W array with a byte-strobed synchronous write port and a registered read port.

Test Plan:
- Single write, then read: AW addr=0x40 len=0, W data=0xDEADBEEF strb=0xF wlast=1 -> bvalid 1 cycle after W; AR addr=0x40 len=0 -> rdata=0xDEADBEEF, rlast=1, rvalid 1 cycle after AR.
- 16-beat burst: write data 0..15 at 0x100 with len=15, then read back with rready held high -> 16 consecutive R beats 0..15; rlast only on beat 16; proto_err=0.
- Byte strobes: write 0xFFFFFFFF, then 0x00000000 with strb=0x5 -> read 0xFF00FF00.
- Wrap: write len=3 starting at word MEM_DEPTH_WORDS-2 -> words DEPTH-2, DEPTH-1, 0, 1 written; reading word 0 returns beat 3.
- Protocol error: len=3 with wlast on beat 2 -> bvalid after beat 2, proto_err=1 and held; reset -> proto_err=0.
- Reset mid-read: assert rst during beat 5 of a len=7 read -> next cycle rvalid=0 and arready=1; memory intact on re-read.
